// File: rtl/reg_arb_pkg.sv
// ============================================================================
// Module   : reg_arb_pkg
// Brief    : Shared types and defaults for reg_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int NREQ_DEF     = 4;
  localparam int HOLD_MAX_DEF = 15;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OWNER_W_DEF = owner_w(NREQ_DEF);

endpackage

`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set mask bit at or after start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         valid_o,
  output logic [W-1:0] winner_o
);

  logic [W:0]   sum;
  logic [W-1:0] idx;

  // Descending scan so the smallest offset from start is the last (winning) write.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    sum      = '0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, start_i} + (W + 1)'(k);
      if (sum >= (W + 1)'(N)) sum = sum - (W + 1)'(N);
      idx = sum[W-1:0];
      if (req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Round-robin arbiter with burst lock for a shared 8-bit register
//            write port. Optional hold timeout via macro REG_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [8*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic              reg_en,
  output logic [7:0]        reg_d,
  output logic              busy,
  output logic              timeout
);

  localparam int OW = owner_w(NREQ);

  if (HOLD_MAX < 1) begin : g_hold_chk
    $error("HOLD_MAX must be at least 1");
  end

  state_t          state_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_q;
  logic [NREQ-1:0] gnt_q;

  logic [OW-1:0]   w_base;
  logic [OW-1:0]   w_start;
  logic [NREQ-1:0] w_mask;
  logic            w_valid;
  logic [OW-1:0]   w_winner;
  logic            w_hold_req;
  logic            w_force;
  logic            w_release;
  logic            w_new;
  logic [7:0]      w_slice;

  // The current owner is always excluded from a handoff, which also makes it last in order.
  assign w_base     = (state_q == ST_IDLE) ? last_q : owner_q;
  assign w_start    = (w_base == OW'(NREQ - 1)) ? '0 : w_base + 1'b1;
  assign w_mask     = (state_q == ST_IDLE) ? req : (req & ~gnt_q);
  assign w_hold_req = (state_q == ST_GRANT) && lock[owner_q] && req[owner_q];
  assign w_release  = (state_q == ST_GRANT) && (!w_hold_req || w_force);
  assign w_new      = w_valid && ((state_q == ST_IDLE) || w_release);

  rr_pick #(
    .N (NREQ),
    .W (OW)
  ) u_rr_pick (
    .req_i    (w_mask),
    .start_i  (w_start),
    .valid_o  (w_valid),
    .winner_o (w_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OW'(NREQ - 1);
      last_q  <= OW'(NREQ - 1);
      gnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_valid) begin
            state_q <= ST_GRANT;
            owner_q <= w_winner;
            gnt_q   <= NREQ'(1) << w_winner;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            last_q <= owner_q;
            if (w_valid) begin
              owner_q <= w_winner;
              gnt_q   <= NREQ'(1) << w_winner;
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef REG_ARB_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);

  logic [HW-1:0] hold_q;
  logic          timeout_q;

  // hold_q counts completed cycles, so the limit hits during the HOLD_MAX-th grant cycle.
  assign w_force = w_hold_req && (hold_q == HW'(HOLD_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= w_force;
      if (w_new)
        hold_q <= '0;
      else if (w_hold_req && !w_force)
        hold_q <= hold_q + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_slice = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) w_slice = wdata[8*i +: 8];
    end
  end

  assign gnt    = gnt_q;
  assign busy   = (state_q == ST_GRANT);
  assign reg_en = gnt_q[owner_q] & req[owner_q];
  assign reg_d  = (|gnt_q) ? w_slice : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// Module   : tb_reg_write_arbiter
// Brief    : Directed self-checking bench for reg_write_arbiter (default NREQ=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        reg_en;
  logic [7:0]  reg_d;
  logic        busy;
  logic        timeout;

  logic [7:0]  shadow;
  int          errors;
  int          checks;
  int          cnt [4];

  reg_write_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .reg_en  (reg_en),
    .reg_d   (reg_d),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared register model: captures on the falling edge.
  initial shadow = 8'h00;
  always @(negedge clk) if (reg_en) shadow <= reg_d;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    logic       exp_t;
    errors = 0;
    checks = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    lock  = 4'b0000;
    wdata = 32'h44_33_22_11;

    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_reg_en", 32'(reg_en), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_reg_d", 32'(reg_d), 32'h0);

    rst = 1'b0;
    tick();
    check("idle_no_req_gnt", 32'(gnt), 32'h0);

    // Alternating pair, no lock
    req = 4'b0101;
    tick();
    check("alt1_gnt", 32'(gnt), 32'h1);
    check("alt1_reg_en", 32'(reg_en), 32'h1);
    check("alt1_reg_d", 32'(reg_d), 32'h11);
    check("alt1_busy", 32'(busy), 32'h1);
    tick();
    check("alt2_gnt", 32'(gnt), 32'h4);
    check("alt2_reg_d", 32'(reg_d), 32'h33);
    tick();
    check("alt3_gnt", 32'(gnt), 32'h1);
    check("alt3_reg_d", 32'(reg_d), 32'h11);

    req = 4'b0000;
    #1;
    check("withdraw_reg_en", 32'(reg_en), 32'h0);
    tick();
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_reg_d", 32'(reg_d), 32'h0);

    // Locked burst by requester 2 with competitors waiting
    wdata = 32'h44_A5_22_11;
    req   = 4'b0100;
    lock  = 4'b0100;
    tick();
    req = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      check("lock_gnt", 32'(gnt), 32'h4);
      check("lock_reg_en", 32'(reg_en), 32'h1);
      check("lock_reg_d", 32'(reg_d), 32'hA5);
    end
    // Requester 3 withdraws before being served; handoff goes to 0
    req  = 4'b0001;
    lock = 4'b0000;
    tick();
    check("handoff_gnt", 32'(gnt), 32'h1);
    check("handoff_busy", 32'(busy), 32'h1);
    check("handoff_reg_d", 32'(reg_d), 32'h11);

    req = 4'b0000;
    tick();
    check("idle2_gnt", 32'(gnt), 32'h0);

    // Long lock by requester 1 with requester 3 waiting
    req  = 4'b1010;
    lock = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      tick();
`ifdef REG_ARB_TIMEOUT_EN
      exp_g = (c == 16) ? 4'b1000 : 4'b0010;
      exp_t = (c == 16);
`else
      exp_g = 4'b0010;
      exp_t = 1'b0;
`endif
      check("hold_gnt", 32'(gnt), 32'(exp_g));
      check("hold_timeout", 32'(timeout), 32'(exp_t));
      if (c == 1) check("hold_reg_d", 32'(reg_d), 32'h22);
    end

    // Reset in the middle of the burst
    rst = 1'b1;
    tick();
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_reg_en", 32'(reg_en), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_timeout", 32'(timeout), 32'h0);
    #5;
    check("midrst_shadow", 32'(shadow), 32'h22);

    // Full contention after reset: strict 0,1,2,3 rotation
    rst  = 1'b0;
    req  = 4'b1111;
    lock = 4'b0000;
    for (int c = 0; c < 40; c++) begin
      tick();
      check("rr_gnt", 32'(gnt), 32'(4'b0001 << (c % 4)));
      check("rr_onehot", 32'($onehot(gnt)), 32'h1);
      for (int i = 0; i < 4; i++) if (gnt[i]) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) check("rr_count", 32'(cnt[i]), 32'd10);

    req = 4'b0000;
    tick();
    tick();
    check("end_gnt", 32'(gnt), 32'h0);
    check("end_busy", 32'(busy), 32'h0);
    check("end_reg_d", 32'(reg_d), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4; number of requesters sharing one 8-bit register write port.
REQ-002 SHALL have parameter HOLD_MAX, default 15; maximum consecutive locked grant cycles per owner (used only with the timeout feature).
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  NREQ  per-requester write request.
REQ-006 SHALL have port lock  input  NREQ  per-requester burst hold; meaningful only while that requester is granted.
REQ-007 SHALL have port wdata  input  8*NREQ  write data, requester i on bits [8i+7:8i].
REQ-008 SHALL have port gnt  output  NREQ  registered one-hot grant.
REQ-009 SHALL have port reg_en  output  1  write enable to the shared 8-bit register.
REQ-010 SHALL have port reg_d  output  8  write data to the shared 8-bit register.
REQ-011 SHALL have port busy  output  1  high while the FSM is in GRANT.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-013 SHALL implement FSM states IDLE and GRANT; the owner index is held in a register.
REQ-014 IDLE: if any req bit is high at posedge, SHALL pick the winner round-robin from (last_owner+1) mod NREQ upward, set gnt one-hot, and enter GRANT.
REQ-015 Grant latency: req sampled high at edge N SHALL give gnt high for the cycle after edge N; no grant is issued while req is all-zero.
REQ-016 reg_en SHALL be combinational gnt[owner] AND req[owner]; reg_d SHALL equal the owner's wdata slice while gnt is nonzero, and 8'h00 otherwise.
REQ-017 reg_en and reg_d SHALL be driven from posedge state only, so both are stable at the following negedge, where the register captures.
REQ-018 GRANT: if lock[owner] and req[owner] are both high, SHALL stay in GRANT with the same owner.
REQ-019 GRANT: on release (lock or req of owner low), SHALL update last_owner; if another req bit is high it SHALL hand off directly to the next round-robin winner with no IDLE cycle, else SHALL go to IDLE with gnt=0.
REQ-020 A releasing owner that still requests SHALL be considered last in the round-robin order, so other requesters win first.
REQ-021 Simultaneous requests SHALL never produce more than one gnt bit high; gnt SHALL be all-zero or exactly one-hot every cycle.
REQ-022 A request withdrawn before it is granted SHALL be dropped without any write.

Reset
REQ-023 While rst is high at posedge: state SHALL be IDLE, gnt=0, busy=0, timeout=0, last_owner=NREQ-1 (so requester 0 wins first), hold counter=0.
REQ-024 rst asserted mid-GRANT SHALL drop gnt and reg_en in the next cycle; the in-flight burst SHALL be abandoned with no further write.

Configuration
REQ-025 Macro REG_ARB_TIMEOUT_EN: when defined, a hold counter SHALL count consecutive GRANT cycles of one owner; it resets on every new grant.
REQ-026 With REG_ARB_TIMEOUT_EN: when the counter reaches HOLD_MAX while the owner holds lock, the arbiter SHALL force release, pulse timeout for one cycle, and exclude that owner from the immediately following arbitration.
REQ-027 Without REG_ARB_TIMEOUT_EN: no counter SHALL be present, timeout SHALL be tied 0, and lock SHALL hold the grant indefinitely.

Structure
REQ-028 Package reg_arb_pkg SHALL hold the state encoding (IDLE, GRANT), the NREQ default, the HOLD_MAX default, and the owner-index width.
REQ-029 Round-robin selection SHALL be one sub-module, rr_pick: inputs req mask and start index; outputs valid and winner index; purely combinational.

Verification
REQ-030 Reset, then req=4'b0101 with lock=0 -> gnt=0001 first, then 0100, then 0001; writes alternate, and reg_d matches the wdata slices.
REQ-031 req[2]=1, lock[2]=1 for 5 cycles, wdata[23:16]=8'hA5, other req high -> gnt stays 0100 for 5 cycles with reg_en=1 and reg_d=A5, then hands off with no IDLE gap.
REQ-032 With REG_ARB_TIMEOUT_EN and HOLD_MAX=15, req[1] and lock[1] held 20 cycles, req[3]=1 -> forced release at cycle 15, timeout pulses once, gnt=1000 next.
REQ-033 rst pulsed during a locked burst -> next cycle gnt=0, reg_en=0, busy=0; the register retains its last written value; arbitration restarts at requester 0.
REQ-034 req=4'b1111 constant for 40 cycles -> gnt always one-hot; each requester is granted exactly 10 times in order 0,1,2,3.
